// File: rtl/mdu_pkg.sv
// Shared encodings for the pipelined CPU multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_shift_core.sv
// Iterative magnitude datapath: shift-add multiply or restoring divide, one step per enabled cycle.
// After WIDTH steps {acc, mq} holds the product, or acc = remainder and mq = quotient.
module mdu_shift_core
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] mq
);

  logic [WIDTH-1:0] md;
  logic             div_mode;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mq_next;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, md};
    shifted  = {acc, mq[WIDTH-1]};
    diff     = shifted - {1'b0, md};
    acc_next = acc;
    mq_next  = mq;
    if (div_mode) begin
      // A set top bit of diff means the trial subtraction borrowed: keep the shifted remainder.
      if (diff[WIDTH]) begin
        acc_next = shifted[WIDTH-1:0];
        mq_next  = {mq[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = diff[WIDTH-1:0];
        mq_next  = {mq[WIDTH-2:0], 1'b1};
      end
    end else begin
      if (mq[0]) {acc_next, mq_next} = {sum, mq[WIDTH-1:1]};
      else       {acc_next, mq_next} = {1'b0, acc, mq[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc      <= '0;
      mq       <= '0;
      md       <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      mq       <= a_mag;
      md       <= b_mag;
      div_mode <= is_div;
    end else if (step) begin
      acc <= acc_next;
      mq  <= mq_next;
    end
  end

endmodule

// File: rtl/pipe_mdu_ctrl.sv
// Multiply/divide controller: FSM, step counter, sign fix-up, HI/LO and pipeline hold.
// Optional MDU_FAST_MUL_EN: multiplies use a single-cycle product and skip the CALC phase.
module pipe_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             mdu_wpcir
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mdu_state_e         state, state_next, start_state;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   core_acc, core_mq;
  logic               is_div_q, neg_q_q, neg_r_q, b_zero_q;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0]   hi_res, lo_res;

  assign accept    = start && (state == IDLE || state == DONE);
  assign signed_op = ~op[0];
  assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

  assign busy      = (state == CALC) || (state == FIX);
  assign done      = (state == DONE);
  assign mdu_wpcir = ~(busy & (start | rd_hilo | mthi | mtlo));

  mdu_shift_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .resetn (resetn),
    .load   (accept),
    .step   (state == CALC),
    .is_div (op[1]),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (core_acc),
    .mq     (core_mq)
  );

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;

  always_ff @(posedge clock) begin
    if (!resetn)                fast_prod <= '0;
    else if (accept && !op[1])  fast_prod <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  end

  assign prod_mag    = fast_prod;
  assign start_state = op[1] ? CALC : FIX;
`else
  assign prod_mag    = {core_acc, core_mq};
  assign start_state = CALC;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = start ? start_state : IDLE;
      CALC:       if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:        state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept)              cnt <= '0;
      else if (state == CALC)  cnt <= cnt + 1'b1;
    end
  end

  // Signs are captured at accept so the core can iterate on magnitudes only.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      b_zero_q <= 1'b0;
      a_q      <= '0;
    end else if (accept) begin
      is_div_q <= op[1];
      neg_q_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r_q  <= signed_op & a[WIDTH-1];
      b_zero_q <= (b == '0);
      a_q      <= a;
    end
  end

  always_comb begin
    prod_res = neg_q_q ? -prod_mag : prod_mag;
    hi_res   = prod_res[2*WIDTH-1:WIDTH];
    lo_res   = prod_res[WIDTH-1:0];
    if (is_div_q) begin
      if (b_zero_q) begin
        hi_res = a_q;
        lo_res = '1;
      end else begin
        hi_res = neg_r_q ? -core_acc : core_acc;
        lo_res = neg_q_q ? -core_mq : core_mq;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      hi <= hi_res;
      lo <= lo_res;
    end else if (!busy && !start) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Scoreboard bench for pipe_mdu_ctrl: stimulus pushes expected HI/LO, done cycle and busy length.
module tb_pipe_mdu_ctrl;

  localparam int unsigned W = 32;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    int          busy_len;
  } exp_t;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         rd_hilo = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, mdu_wpcir;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_run = 0;
  exp_t sb[$];

  pipe_mdu_ctrl #(.WIDTH(W)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .rd_hilo   (rd_hilo),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .mdu_wpcir (mdu_wpcir)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest pending expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!resetn) begin
      busy_run = 0;
    end else begin
      if (start && (mthi || mtlo)) begin
        n_cmp++;
        n_err++;
        $display("FAIL start_mt_overlap: got start with mthi/mtlo expected exclusive");
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"}, hi, e.hi);
          check({e.name, "_lo"}, lo, e.lo);
          check({e.name, "_done_cycle"}, cyc, e.cyc);
          check({e.name, "_busy_len"}, busy_run, e.busy_len);
        end
        busy_run = 0;
      end else if (busy) begin
        busy_run++;
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input string name, input bit push, output int c0);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clock);
    #1;
    c0    = cyc;
    start = 1'b0;
    if (push) sb.push_back('{name: name, hi: ehi, lo: elo, cyc: c0 + int'(W) + 1, busy_len: int'(W) + 1});
  endtask

  task automatic wait_empty();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got %0d pending ops expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int c0, c1, bad;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_wpcir", mdu_wpcir, 1'b1);
    resetn = 1'b1;

    @(negedge clock);
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", 1'b1, c0);
    wait_empty();
    launch(2'b00, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg", 1'b1, c0);
    wait_empty();
    launch(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg", 1'b1, c0);
    wait_empty();
    launch(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, "divu_zero", 1'b1, c0);
    wait_empty();
    launch(2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_zero", 1'b1, c0);
    wait_empty();
    launch(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_ovf", 1'b1, c0);
    wait_empty();

    // MFHI/MFLO stall from cycle 5, plus an MTHI attempt while busy that must be ignored
    launch(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_stall", 1'b1, c0);
    bad = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clock);
      if (k == 5) rd_hilo = 1'b1;
      if (k == 10) begin
        mthi  = 1'b1;
        wdata = 32'hDEAD0000;
      end
      if (k == 11) mthi = 1'b0;
      #1;
      if (k <= 33) begin
        if (mdu_wpcir !== ((k >= 5) ? 1'b0 : 1'b1)) bad++;
      end else begin
        check1("stall_release_c34", mdu_wpcir, 1'b1);
      end
    end
    check("stall_window_bad_cycles", bad, 32'd0);
    rd_hilo = 1'b0;
    wait_empty();

    // Reset in cycle 10 of a MULT: op discarded, no done
    @(negedge clock);
    launch(2'b00, 32'd5, 32'd9, 32'd0, 32'd0, "mult_aborted", 1'b0, c0);
    repeat (9) @(negedge clock);
    @(posedge clock);
    #1;
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    check1("midreset_busy", busy, 1'b0);
    check1("midreset_done", done, 1'b0);
    check("midreset_hi", hi, 32'h0);
    check("midreset_lo", lo, 32'h0);
    repeat (40) @(negedge clock);
    launch(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "multu_after_reset", 1'b1, c0);
    wait_empty();

    // MTLO/MTHI while idle
    @(negedge clock);
    mtlo  = 1'b1;
    wdata = 32'h55;
    @(posedge clock);
    #1;
    mtlo = 1'b0;
    check("mtlo_idle", lo, 32'h55);
    check("mtlo_idle_hi_kept", hi, 32'h0);
    mthi  = 1'b1;
    wdata = 32'hAA;
    @(posedge clock);
    #1;
    mthi = 1'b0;
    check("mthi_idle", hi, 32'hAA);

    // MTLO in DONE overrides the freshly written LO, HI keeps the op result
    @(negedge clock);
    launch(2'b11, 32'd9, 32'd4, 32'd1, 32'd2, "divu_done_mt", 1'b1, c0);
    repeat (34) @(negedge clock);
    check1("done_in_cycle34", done, 1'b1);
    mtlo  = 1'b1;
    wdata = 32'h77;
    @(posedge clock);
    #1;
    mtlo = 1'b0;
    check("mtlo_in_done_lo", lo, 32'h77);
    check("mtlo_in_done_hi", hi, 32'h1);
    wait_empty();

    // Back-to-back: second start presented during DONE, done at cycles 34 and 68
    @(negedge clock);
    launch(2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, "b2b_first", 1'b1, c0);
    repeat (34) @(negedge clock);
    check1("b2b_done_before_second", done, 1'b1);
    check1("b2b_wpcir_in_done", mdu_wpcir, 1'b1);
    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, "b2b_second", 1'b1, c1);
    check1("b2b_busy_no_bubble", busy, 1'b1);
    wait_empty();

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
